// File: rtl/ram_scan_reader_if.sv
// Bus between the scan reader, the RAM read port and the board HEX/LED outputs.
// master = scan reader, slave = RAM model / board side.
interface ram_scan_reader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rden;
    logic [DATA_W-1:0] ram_q;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              wrap;
    logic              LEDG;
    logic [27:0]       HEX;

    modport master (
        output ram_addr, ram_rden, data_out, data_valid, wrap, LEDG, HEX,
        input  ram_q
    );

    modport slave (
        input  ram_addr, ram_rden, data_out, data_valid, wrap, LEDG, HEX,
        output ram_q
    );
endinterface

// File: rtl/ram_scan_reader.sv
// Sweeps a synchronous RAM from address 0 upward, holding each word on
// registered outputs and the HEX display, advancing on a timer or a KEY press.
module ram_scan_reader #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8,
    parameter int RD_LAT   = 1,
    parameter int TICK_DIV = 50000000
) (
    input  logic clk50M,
    input  logic reset,
    input  logic run,
    input  logic step_n,
    ram_scan_reader_if.master bus
);
    localparam int                TICK_W    = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [1:0]        LAT_LAST  = 2'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              wrap_q, wrap_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [1:0]        lat_q, lat_d;
    logic              sync1_q, sync2_q, prev_q;
    logic              stepPulse;
    logic              advance;
    logic [7:0]        dispData;
    logic [4:0]        dispAddr;

    function automatic logic [6:0] hexTo7Seg(input logic [3:0] nib);
        case (nib)
            4'h0: hexTo7Seg = 7'b1000000;
            4'h1: hexTo7Seg = 7'b1111001;
            4'h2: hexTo7Seg = 7'b0100100;
            4'h3: hexTo7Seg = 7'b0110000;
            4'h4: hexTo7Seg = 7'b0011001;
            4'h5: hexTo7Seg = 7'b0010010;
            4'h6: hexTo7Seg = 7'b0000010;
            4'h7: hexTo7Seg = 7'b1111000;
            4'h8: hexTo7Seg = 7'b0000000;
            4'h9: hexTo7Seg = 7'b0010000;
            4'hA: hexTo7Seg = 7'b0001000;
            4'hB: hexTo7Seg = 7'b0000011;
            4'hC: hexTo7Seg = 7'b1000110;
            4'hD: hexTo7Seg = 7'b0100001;
            4'hE: hexTo7Seg = 7'b0000110;
            default: hexTo7Seg = 7'b0001110;
        endcase
    endfunction

    // Falling edge of the synchronised key: holding the key gives one pulse.
    assign stepPulse = prev_q & ~sync2_q;

    always_ff @(posedge clk50M) begin
        if (!reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            tick_q  <= '0;
            lat_q   <= '0;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            tick_q  <= tick_d;
            lat_q   <= lat_d;
            sync1_q <= step_n;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = valid_q;
        wrap_d  = 1'b0;
        tick_d  = tick_q;
        lat_d   = lat_q;
        advance = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                lat_d   = '0;
                valid_d = 1'b0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    data_d  = bus.ram_q;
                    valid_d = 1'b1;
                    tick_d  = '0;
                    state_d = S_HOLD;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            S_HOLD: begin
                // A key press and the timer expiring together still move one word.
                advance = stepPulse | (run & (tick_q == TICK_LAST));
                tick_d  = run ? tick_q + TICK_W'(1) : '0;
                if (advance) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    valid_d = 1'b0;
                    wrap_d  = (addr_q == ADDR_LAST);
                    tick_d  = '0;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.ram_rden = (state_q == S_REQ);
        dispData     = 8'(data_q);
        dispAddr     = 5'(addr_q);
        bus.HEX      = {hexTo7Seg({3'b000, dispAddr[4]}), hexTo7Seg(dispAddr[3:0]),
                        hexTo7Seg(dispData[7:4]), hexTo7Seg(dispData[3:0])};
    end

    assign bus.ram_addr   = addr_q;
    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.wrap       = wrap_q;
    assign bus.LEDG       = valid_q;
endmodule

// File: tb/tb_ram_scan_reader.sv
// Directed bench for ram_scan_reader: one instance with RD_LAT=1 for the sweep,
// step and wrap cases, and one with RD_LAT=2 for reset during a pending read.
module tb_ram_scan_reader;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam logic [27:0] HEX_ZERO = {4{7'b1000000}};

    logic clk50M = 1'b0;
    always #5 clk50M = ~clk50M;

    logic resetA, runA, stepA;
    logic resetB, runB, stepB;

    ram_scan_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) busA ();
    ram_scan_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) busB ();

    ram_scan_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1), .TICK_DIV(4)) dutA (
        .clk50M(clk50M), .reset(resetA), .run(runA), .step_n(stepA), .bus(busA)
    );

    ram_scan_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(2), .TICK_DIV(4)) dutB (
        .clk50M(clk50M), .reset(resetB), .run(runB), .step_n(stepB), .bus(busB)
    );

    // RAM contents mem[i] = 3*i, so address 31 holds 8'h5D.
    logic [7:0] mem [32];
    logic [7:0] pipeB;
    initial for (int i = 0; i < 32; i++) mem[i] = 8'(3 * i);

    always @(posedge clk50M) begin
        if (busA.ram_rden) busA.ram_q <= mem[busA.ram_addr];
        if (busB.ram_rden) pipeB <= mem[busB.ram_addr];
        busB.ram_q <= pipeB;
    end

    int vecCount = 0;
    int missCount = 0;
    int cyc = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk50M);
            #1;
            cyc++;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic rn, input logic s, input int n);
        resetA = r;
        runA   = rn;
        stepA  = s;
        tick(n);
    endtask

    int n, hold, tPrev;

    initial begin
        resetA = 1'b0; runA = 1'b1; stepA = 1'b1;
        resetB = 1'b0; runB = 1'b0; stepB = 1'b1;
        tPrev = 0;

        $display("[TB] reset hold");
        repeat (3) begin
            tick(1);
            checkOutput("rst_addr", busA.ram_addr, 0);
            checkOutput("rst_valid", busA.data_valid, 0);
            checkOutput("rst_hex", busA.HEX, HEX_ZERO);
        end
        checkOutput("rst_data", busA.data_out, 0);
        checkOutput("rst_wrap", busA.wrap, 0);
        checkOutput("rst_ledg", busA.LEDG, 0);
        resetA = 1'b1;
        checkOutput("idle_rden", busA.ram_rden, 0);
        tick(1);
        checkOutput("req_rden", busA.ram_rden, 1);
        checkOutput("req_addr", busA.ram_addr, 0);

        $display("[TB] auto-run");
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (busA.data_valid !== 1'b1 && n < 20) begin tick(1); n++; end
            checkOutput("auto_valid", busA.data_valid, 1);
            checkOutput($sformatf("auto_data%0d", k), busA.data_out, 3 * k);
            checkOutput($sformatf("auto_addr%0d", k), busA.ram_addr, k);
            checkOutput("auto_ledg", busA.LEDG, 1);
            if (k > 0) checkOutput("auto_period", cyc - tPrev, 6);
            if (k == 1) checkOutput("auto_hex_data", busA.HEX[13:0], {7'b1000000, 7'b0110000});
            tPrev = cyc;
            hold = 0;
            while (busA.data_valid === 1'b1 && hold < 20) begin tick(1); hold++; end
            checkOutput("auto_hold", hold, 4);
        end

        $display("[TB] wrap");
        n = 0;
        while (!(busA.ram_addr == 5'd31 && busA.data_valid === 1'b1) && n < 400) begin tick(1); n++; end
        checkOutput("wrap_reach", busA.ram_addr, 31);
        checkOutput("wrap_data", busA.data_out, 8'h5D);
        checkOutput("wrap_pre", busA.wrap, 0);
        n = 0;
        while (busA.data_valid === 1'b1 && n < 20) begin tick(1); n++; end
        checkOutput("wrap_addr", busA.ram_addr, 0);
        checkOutput("wrap_pulse", busA.wrap, 1);
        checkOutput("wrap_rden", busA.ram_rden, 1);
        checkOutput("wrap_keep_data", busA.data_out, 8'h5D);
        checkOutput("wrap_hex_addr", busA.HEX[27:14], {7'b1000000, 7'b1000000});
        runA = 1'b0;
        tick(1);
        checkOutput("wrap_clear", busA.wrap, 0);

        $display("[TB] step mode");
        n = 0;
        while (busA.data_valid !== 1'b1 && n < 20) begin tick(1); n++; end
        tick(10);
        checkOutput("idle_hold_addr", busA.ram_addr, 0);
        checkOutput("idle_hold_valid", busA.data_valid, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 3);
        applyStimulus(1'b1, 1'b0, 1'b1, 10);
        checkOutput("short_addr", busA.ram_addr, 1);
        checkOutput("short_data", busA.data_out, 3);
        checkOutput("short_valid", busA.data_valid, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 200);
        applyStimulus(1'b1, 1'b0, 1'b1, 10);
        checkOutput("long_addr", busA.ram_addr, 2);
        checkOutput("long_data", busA.data_out, 6);
        // Second falling edge reaches the detector while the read is in flight.
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        applyStimulus(1'b1, 1'b0, 1'b1, 10);
        checkOutput("bounce_addr", busA.ram_addr, 3);
        checkOutput("bounce_data", busA.data_out, 9);
        checkOutput("bounce_valid", busA.data_valid, 1);

        $display("[TB] step and tick collision");
        applyStimulus(1'b1, 1'b1, 1'b1, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 2);
        checkOutput("coll_pre_addr", busA.ram_addr, 3);
        tick(1);
        checkOutput("coll_addr", busA.ram_addr, 4);
        checkOutput("coll_rden", busA.ram_rden, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        applyStimulus(1'b1, 1'b0, 1'b1, 10);
        checkOutput("coll_final_addr", busA.ram_addr, 4);
        checkOutput("coll_final_data", busA.data_out, 12);

        $display("[TB] reset during pending read");
        runB = 1'b1;
        resetB = 1'b1;
        n = 0;
        while (!(busB.ram_addr == 5'd7 && busB.ram_rden === 1'b1) && n < 200) begin tick(1); n++; end
        checkOutput("b_req_addr", busB.ram_addr, 7);
        tick(1);
        checkOutput("b_wait_data", busB.data_out, 18);
        checkOutput("b_wait_valid", busB.data_valid, 0);
        resetB = 1'b0;
        tick(1);
        checkOutput("b_rst_addr", busB.ram_addr, 0);
        checkOutput("b_rst_valid", busB.data_valid, 0);
        checkOutput("b_rst_data", busB.data_out, 0);
        checkOutput("b_rst_wrap", busB.wrap, 0);
        checkOutput("b_rst_rden", busB.ram_rden, 0);
        tick(1);
        checkOutput("b_rst_nocapture", busB.data_out, 0);
        resetB = 1'b1;
        n = 0;
        while (busB.data_valid !== 1'b1 && n < 20) begin tick(1); n++; end
        checkOutput("b_restart_addr", busB.ram_addr, 0);
        checkOutput("b_restart_data", busB.data_out, 0);
        checkOutput("b_restart_valid", busB.data_valid, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end
endmodule

// File: doc/ram_scan_reader.md
Name: ram_scan_reader

Overview:
- Read-side companion to the switch-driven RAM writer.
- Sweeps a synchronous single-port RAM (32 x 8 by default) from address 0 upward, issues one-cycle read requests and captures each returned word.
- Holds each word on registered outputs and on four active-low 7-segment digits, either for a fixed number of clocks (auto-run) or until a KEY press (single-step).
- Sits between the RAM's read port and the board HEX/LED outputs.

Parameters:
ADDR_W, 5, RAM address width; the sweep wraps at 2^ADDR_W-1 -> 0
DATA_W, 8, RAM word width (display logic fixed to 8)
RD_LAT, 1, clocks from read-request edge to valid ram_q (1 or 2)
TICK_DIV, 50000000, clk50M cycles each word is held in auto-run (>=2)

Ports:
clk50M  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-low reset
run  in  1  level (SW): 1 = auto-advance every TICK_DIV cycles
step_n  in  1  active-low KEY, asynchronous; each press advances one word
ram_q  in  DATA_W  RAM read data
ram_addr  out  ADDR_W  registered read address
ram_rden  out  1  read strobe, one cycle per word
data_out  out  DATA_W  last captured word
data_valid  out  1  high while data_out matches ram_addr
wrap  out  1  one-cycle pulse when the address rolls over to 0
LEDG  out  1  = data_valid
HEX  out  28  [6:0] data low nibble, [13:7] data high nibble, [20:14] addr[3:0], [27:21] {000,addr[4]}; active-low, standard 0-F glyphs

Behaviour:
- Reset (reset=0 at a clk50M edge):
  - State = IDLE.
  - ram_addr=0, ram_rden=0, data_out=0, data_valid=0, wrap=0, tick counter=0.
  - Step synchroniser flops = 1.
  - HEX shows "0000" (every digit 7'b1000000).
  - A reset in any state, including REQ or WAIT, aborts the read with no capture.
- step_n handling: 2-FF synchroniser, then a falling-edge detector producing a one-cycle step_pulse. Holding the key low gives exactly one pulse.
- FSM:
  - IDLE: one cycle after reset release -> REQ (auto-loads address 0).
  - REQ: ram_rden=1; ram_addr stable; data_valid=0 -> WAIT.
  - WAIT: RD_LAT cycles, with a counter. At the last WAIT edge: data_out<=ram_q, data_valid<=1, tick counter<=0 -> HOLD.
  - HOLD: ram_rden=0; tick counter increments.
    - Advance if step_pulse=1, or if run=1 and tick==TICK_DIV-1.
    - On advance: ram_addr<=ram_addr+1 (modulo 2^ADDR_W), data_valid<=0 -> REQ.
- Per-word period in auto-run: 1+RD_LAT+TICK_DIV cycles.
- Simultaneous step_pulse and tick terminal count: a single advance.
- step_pulse outside HOLD (IDLE/REQ/WAIT): dropped, not queued.
- run dropped mid-HOLD: hold indefinitely; the tick counter is reset to 0 while run=0.
- Wrap:
  - On advance from address 2^ADDR_W-1, ram_addr becomes 0.
  - wrap=1 for exactly the following cycle, coincident with REQ.
- data_out holds its previous value through REQ/WAIT. Only data_valid drops.
- HEX and LEDG are combinational decodes of the registered ram_addr, data_out and data_valid, using the team's standard hex-to-7-segment decoder.

Test Plan:
1. Reset hold: reset=0 for 3 cycles, then release -> during reset: ram_addr=0, data_valid=0, HEX=28'h81_02_04_0 pattern (four 7'b1000000); after release: ram_rden=1 on the 2nd cycle with ram_addr=0.
2. Auto-run (RD_LAT=1, TICK_DIV=4, RAM model mem[i]=3*i, run=1) -> data_out sequence 00,03,06,09, each with data_valid=1 for exactly 4 cycles; one new word every 6 cycles; HEX[13:0] shows "03" while ram_addr=1.
3. Wrap: run until ram_addr=31, data_out=8'h5D -> next REQ has ram_addr=0, wrap=1 for one cycle, HEX address digits show "00".
4. Step mode (run=0):
   - step_n low 3 cycles -> exactly one advance.
   - step_n low 200 cycles -> exactly one advance.
   - Press landing during REQ/WAIT -> ignored; address unchanged after the capture.
5. Collision: run=1, TICK_DIV=4, step_pulse on the same cycle as tick==3 -> ram_addr increments by 1, not 2.
6. Reset mid-read: RD_LAT=2, assert reset during the 1st WAIT cycle at ram_addr=7 -> next cycle ram_addr=0, data_valid=0, data_out=0, wrap=0; no capture of the address-7 data.
